fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
- Holds the PC and addresses instruction memory.
- Presents each fetched instruction to the decode stage, which extracts op/funct for the control decoder.
- Handles decode-stage stall, branch/jump redirects (with IF/ID flush), and terminate-driven pipeline drain and halt.

Parameters:
- WORD, 32, datapath/instruction width in bits.
- IMEM_AW, 9, instruction memory word-address width (512 words).
- PC_RESET, 32'h0000_0000, byte address loaded into PC on reset.
- DRAIN_CYCLES, 4, cycles after terminate before halted asserts (ID->EX->MEM->WB).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode; freeze PC and IF/ID.
- branch_taken  in  1  branch resolved taken in decode.
- branch_target  in  WORD  byte address for taken branch.
- jump_taken  in  1  jump in decode.
- jump_target  in  WORD  byte address for jump.
- terminate  in  1  halt instruction (op=funct=6'b111111) decoded.
- imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2].
- imem_data  in  WORD  instruction word, combinational read of imem_addr.
- pc  out  WORD  current fetch PC.
- if_id_instr  out  WORD  registered instruction to decode.
- if_id_pc4  out  WORD  registered PC+4 of that instruction.
- if_id_valid  out  1  if_id_instr is a real instruction (0 = bubble).
- halted  out  1  pipeline fully drained after terminate.
- fetch_count  out  WORD  number of instructions loaded valid into IF/ID.

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - pc=PC_RESET.
  - if_id_instr=0, if_id_pc4=0, if_id_valid=0.
  - halted=0, fetch_count=0, state=RUN, drain counter=0.
- imem_addr is combinational from pc. Memory read has zero-cycle latency; instruction is captured into IF/ID on the same edge that advances PC.
- FSM states: RUN, DRAIN, HALTED.
- RUN, per-edge priority, highest first:
  1. terminate && !stall -> pc held; IF/ID := bubble (instr=0, valid=0); drain counter := 0; state := DRAIN.
  2. stall -> pc, IF/ID, and fetch_count all held. Redirect and terminate inputs are ignored this cycle; decode re-presents them once the stall drops.
  3. jump_taken -> pc := jump_target; IF/ID := bubble. No delay slot.
  4. branch_taken -> pc := branch_target; IF/ID := bubble. jump_taken wins if both are asserted.
  5. otherwise -> IF/ID := {imem_data, pc+4, valid=1}; pc := pc+4; fetch_count += 1.
- DRAIN:
  - pc frozen; IF/ID held as bubble; all inputs except rst ignored.
  - Counter increments each cycle; on reaching DRAIN_CYCLES-1 -> HALTED.
  - halted rises exactly DRAIN_CYCLES cycles after the terminate edge.
- HALTED: halted=1, pc frozen, IF/ID bubble. Only rst exits.
- Arithmetic:
  - pc+4 and fetch_count wrap modulo 2^WORD; no saturation.
  - imem_addr truncates pc, so fetch wraps within imem.
  - Redirect targets are taken verbatim; low two bits are not checked, and imem_addr ignores them.
- Reset asserted mid-DRAIN or mid-stall returns to the reset state on that edge; the next edge fetches from PC_RESET.
- No combinational path from stall/branch/jump/terminate to any output. imem_addr depends only on pc.

Test Plan:
1. Sequential fetch: reset; imem[0..3]=11,22,33,44; run 4 cycles -> if_id_instr 11,22,33,44 with if_id_pc4 4,8,12,16; valid=1; fetch_count=4; pc=16.
2. Stall: at pc=8 assert stall for 3 cycles -> pc stays 8, IF/ID keeps instr 22 / pc4 8, fetch_count constant. After release, the next edge loads instr 33.
3. Branch redirect: at pc=12, branch_taken=1, branch_target=0x40 -> next cycle pc=0x40, IF/ID valid=0 with instr=0. The following edge loads imem[16], pc4=0x44.
4. Jump vs branch and stall priority:
   - jump_taken=1 with target 0x80, branch_taken=1 with target 0x40 in the same cycle -> pc=0x80.
   - stall=1 with jump_taken=1 -> pc unchanged.
5. Terminate/drain: terminate=1 at cycle N -> IF/ID bubble from N+1; halted=0 through N+3, 1 at N+4. After that, toggling branch_taken or jump_taken leaves pc unchanged.
6. Reset mid-DRAIN and wrap: assert rst two cycles after terminate -> halted=0, pc=0 next cycle. Separately, PC_RESET=32'hFFFF_FFFC -> after one fetch pc=0, imem_addr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
// Holds the PC, addresses instruction memory combinationally, and captures the
// fetched word into IF/ID. Handles decode stalls, jump/branch redirects with an
// IF/ID flush, and terminate-driven drain followed by a sticky halt.
module fetch_stage #(
  parameter int unsigned     WORD         = 32,
  parameter int unsigned     IMEM_AW      = 9,
  parameter logic [WORD-1:0] PC_RESET     = 32'h0000_0000,
  parameter int unsigned     DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [WORD-1:0]    branch_target,
  input  logic               jump_taken,
  input  logic [WORD-1:0]    jump_target,
  input  logic               terminate,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [WORD-1:0]    imem_data,
  output logic [WORD-1:0]    pc,
  output logic [WORD-1:0]    if_id_instr,
  output logic [WORD-1:0]    if_id_pc4,
  output logic               if_id_valid,
  output logic               halted,
  output logic [WORD-1:0]    fetch_count
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [WORD-1:0]  pc_q, pc_d;
  logic [WORD-1:0]  instr_q, instr_d;
  logic [WORD-1:0]  pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [WORD-1:0]  fcnt_q, fcnt_d;
  logic [WORD-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + WORD'(4);

  // Outputs come straight from flops; imem_addr depends only on the PC.
  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = fcnt_q;

  // Next-state and IF/ID next-value selection; everything defaults to hold.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (terminate && !stall) begin
          // Stop fetching; the instructions already downstream drain out.
          instr_d = '0;
          valid_d = 1'b0;
          dcnt_d  = '0;
          state_d = ST_DRAIN;
        end else if (stall) begin
          // Hold everything; decode re-presents redirects after the stall.
        end else if (jump_taken) begin
          pc_d    = jump_target;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          instr_d = '0;
          valid_d = 1'b0;
        end else begin
          instr_d = imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          fcnt_d  = fcnt_q + WORD'(1);
        end
      end
      ST_DRAIN: begin
        instr_d = '0;
        valid_d = 1'b0;
        if (dcnt_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        instr_d = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register; synchronous reset returns the whole stage to its start point.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      dcnt_q  <= '0;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirects and their
// priority, terminate/drain/halt, reset during drain, and PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump_taken = 1'b0;
  logic [31:0] jump_target = '0;
  logic        terminate = 1'b0;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, halted;

  // Second instance with a reset PC just below the wrap point.
  logic [8:0]  w_imem_addr;
  logic [31:0] w_imem_data;
  logic [31:0] w_pc, w_instr, w_pc4, w_fcnt;
  logic        w_valid, w_halted;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = '0;

  logic [31:0] imem [0:511];

  int total = 0;
  int bad   = 0;

  assign imem_data   = imem[imem_addr];
  assign w_imem_data = imem[w_imem_addr];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .terminate(terminate), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(w_zero),
    .branch_taken(w_zero), .branch_target(w_zero32),
    .jump_taken(w_zero), .jump_target(w_zero32),
    .terminate(w_zero), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .pc(w_pc), .if_id_instr(w_instr), .if_id_pc4(w_pc4),
    .if_id_valid(w_valid), .halted(w_halted), .fetch_count(w_fcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0; terminate = 1'b0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) imem[i] = 32'h0;
    imem[0] = 32'd11; imem[1] = 32'd22; imem[2] = 32'd33; imem[3] = 32'd44;
    imem[16] = 32'd55;
    imem[511] = 32'h99;

    // Reset state
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc4", if_id_pc4, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_fcnt", fetch_count, 32'h0);
    check("rst_addr", {23'b0, imem_addr}, 32'h0);
    check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_rst_addr", {23'b0, w_imem_addr}, 32'd511);

    // Sequential fetch
    step();
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_addr", {23'b0, w_imem_addr}, 32'h0);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_instr", w_instr, 32'h99);
    check("seq_instr0", if_id_instr, 32'd11);
    check("seq_pc4_0", if_id_pc4, 32'd4);
    step();
    check("seq_instr1", if_id_instr, 32'd22);
    check("seq_pc4_1", if_id_pc4, 32'd8);
    step();
    check("seq_instr2", if_id_instr, 32'd33);
    check("seq_pc4_2", if_id_pc4, 32'd12);
    step();
    check("seq_instr3", if_id_instr, 32'd44);
    check("seq_pc4_3", if_id_pc4, 32'd16);
    check("seq_valid", {31'b0, if_id_valid}, 32'h1);
    check("seq_fcnt", fetch_count, 32'd4);
    check("seq_pc", pc, 32'd16);
    check("seq_addr", {23'b0, imem_addr}, 32'd4);

    // Stall at pc=8, with a jump and then a terminate presented during the stall
    do_reset();
    step();
    step();
    check("pre_stall_pc", pc, 32'd8);
    stall = 1'b1;
    step();
    check("stall1_pc", pc, 32'd8);
    jump_taken = 1'b1; jump_target = 32'h80;
    step();
    check("stall_jump_pc", pc, 32'd8);
    jump_taken = 1'b0; terminate = 1'b1;
    step();
    check("stall3_pc", pc, 32'd8);
    check("stall3_instr", if_id_instr, 32'd22);
    check("stall3_pc4", if_id_pc4, 32'd8);
    check("stall3_valid", {31'b0, if_id_valid}, 32'h1);
    check("stall3_fcnt", fetch_count, 32'd2);
    clear_ctl();
    step();
    check("unstall_instr", if_id_instr, 32'd33);
    check("unstall_pc4", if_id_pc4, 32'd12);
    check("unstall_fcnt", fetch_count, 32'd3);
    check("unstall_halted", {31'b0, halted}, 32'h0);

    // Branch redirect at pc=12
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    check("br_pc", pc, 32'h40);
    check("br_valid", {31'b0, if_id_valid}, 32'h0);
    check("br_instr", if_id_instr, 32'h0);
    check("br_fcnt", fetch_count, 32'd3);
    clear_ctl();
    step();
    check("br_next_instr", if_id_instr, 32'd55);
    check("br_next_pc4", if_id_pc4, 32'h44);
    check("br_next_valid", {31'b0, if_id_valid}, 32'h1);

    // Jump beats branch
    jump_taken = 1'b1; jump_target = 32'h80;
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    check("jb_pc", pc, 32'h80);
    check("jb_valid", {31'b0, if_id_valid}, 32'h0);
    check("jb_addr", {23'b0, imem_addr}, 32'h20);
    clear_ctl();

    // Terminate and drain
    terminate = 1'b1;
    step();
    terminate = 1'b0;
    check("term_valid", {31'b0, if_id_valid}, 32'h0);
    check("term_instr", if_id_instr, 32'h0);
    check("term_pc", pc, 32'h80);
    check("drain0_halted", {31'b0, halted}, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("drain%0d_halted", k), {31'b0, halted}, 32'h0);
    end
    step();
    check("drain4_halted", {31'b0, halted}, 32'h1);
    branch_taken = 1'b1; branch_target = 32'h40;
    jump_taken = 1'b1; jump_target = 32'h100;
    step();
    check("halt_pc", pc, 32'h80);
    check("halt_valid", {31'b0, if_id_valid}, 32'h0);
    check("halt_fcnt", fetch_count, 32'd4);
    check("halt_sticky", {31'b0, halted}, 32'h1);
    clear_ctl();

    // Reset two cycles after terminate
    do_reset();
    terminate = 1'b1;
    step();
    terminate = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_halted", {31'b0, halted}, 32'h0);
    check("mid_rst_pc", pc, 32'h0);
    step();
    check("post_rst_instr", if_id_instr, 32'd11);
    check("post_rst_pc", pc, 32'd4);
    repeat (4) step();
    check("post_rst_no_halt", {31'b0, halted}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
